// File: rtl/core_writeback.sv
// core_writeback: drains the output buffer into packed 32-bit DMA words; define CORE_WB_BYTE_SWAP_EN for big-endian lane packing
module core_writeback #(
  parameter int P_FIFO_DEPTH  = 4,
  parameter int P_BLOCK_BYTES = 192
) (
  input  logic        I_WB_HCLK,
  input  logic        I_WB_RESET,
  input  logic        I_WB_START_BLOCK,
  input  logic [7:0]  I_WB_BYTE_COUNT,
  input  logic        I_WB_STOP,
  output logic        O_WB_OMEM_READ,
  output logic [7:0]  O_WB_OMEM_ADDR0,
  output logic [7:0]  O_WB_OMEM_ADDR1,
  output logic [7:0]  O_WB_OMEM_ADDR2,
  output logic [7:0]  O_WB_OMEM_ADDR3,
  input  logic [7:0]  I_WB_OMEM_DATA0,
  input  logic [7:0]  I_WB_OMEM_DATA1,
  input  logic [7:0]  I_WB_OMEM_DATA2,
  input  logic [7:0]  I_WB_OMEM_DATA3,
  output logic [31:0] O_WB_HWDATA,
  output logic [3:0]  O_WB_BYTE_EN,
  output logic        O_WB_VALID,
  input  logic        I_WB_DMA_READY,
  output logic        O_WB_LAST,
  output logic        O_WB_BUSY,
  output logic        O_WB_BLOCK_DONE
);
  localparam int AW = $clog2(P_FIFO_DEPTH);
  localparam logic [8:0] BLK = 9'(P_BLOCK_BYTES);
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  state_t state;
  logic [6:0] words, rd_cnt, words_in;
  logic [3:0] last_be, be_in, lane_be, push_be;
  logic [8:0] bytes_in;
  logic rd_last, if_valid, if_last, push, pop, issue, space;
  logic [31:0] raw, push_data;
  logic [31:0] f_data [P_FIFO_DEPTH];
  logic [3:0] f_be [P_FIFO_DEPTH];
  logic f_last [P_FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt;
  logic [AW+1:0] cnt_nxt;
  always_comb begin
    bytes_in = (I_WB_BYTE_COUNT == 8'd0 || {1'b0, I_WB_BYTE_COUNT} > BLK) ? BLK : {1'b0, I_WB_BYTE_COUNT};
    words_in = 7'((bytes_in + 9'd3) >> 2);
    be_in = bytes_in[1:0] == 2'd1 ? 4'b0001 : bytes_in[1:0] == 2'd2 ? 4'b0011 :
            bytes_in[1:0] == 2'd3 ? 4'b0111 : 4'b1111;
    O_WB_VALID = cnt != '0;
    pop = O_WB_VALID && I_WB_DMA_READY;
    push = if_valid;
    cnt_nxt = (AW+2)'(cnt) + (AW+2)'(push) - (AW+2)'(pop);
    space = cnt_nxt + (AW+2)'(O_WB_OMEM_READ) < (AW+2)'(P_FIFO_DEPTH);
    issue = state == FETCH && rd_cnt < words && space;
    lane_be = if_last ? last_be : 4'hF;
`ifdef CORE_WB_BYTE_SWAP_EN
    push_be = {lane_be[0], lane_be[1], lane_be[2], lane_be[3]};
    raw = {I_WB_OMEM_DATA0, I_WB_OMEM_DATA1, I_WB_OMEM_DATA2, I_WB_OMEM_DATA3};
`else
    push_be = lane_be;
    raw = {I_WB_OMEM_DATA3, I_WB_OMEM_DATA2, I_WB_OMEM_DATA1, I_WB_OMEM_DATA0};
`endif
    push_data = raw & {{8{push_be[3]}}, {8{push_be[2]}}, {8{push_be[1]}}, {8{push_be[0]}}};
    O_WB_HWDATA = O_WB_VALID ? f_data[rptr] : 32'd0;
    O_WB_BYTE_EN = O_WB_VALID ? f_be[rptr] : 4'd0;
    O_WB_LAST = O_WB_VALID && f_last[rptr];
  end
  always_ff @(posedge I_WB_HCLK) begin
    if (I_WB_RESET) begin
      state <= IDLE;
      cnt <= '0;
      wptr <= '0;
      rptr <= '0;
      O_WB_OMEM_READ <= 1'b0;
      if_valid <= 1'b0;
      if_last <= 1'b0;
      rd_last <= 1'b0;
      rd_cnt <= '0;
      words <= '0;
      last_be <= 4'hF;
      O_WB_OMEM_ADDR0 <= 8'd0;
      O_WB_OMEM_ADDR1 <= 8'd1;
      O_WB_OMEM_ADDR2 <= 8'd2;
      O_WB_OMEM_ADDR3 <= 8'd3;
      O_WB_BUSY <= 1'b0;
      O_WB_BLOCK_DONE <= 1'b0;
    end else if (I_WB_STOP && state != IDLE) begin
      state <= IDLE;
      cnt <= '0;
      wptr <= '0;
      rptr <= '0;
      O_WB_OMEM_READ <= 1'b0;
      if_valid <= 1'b0;
      O_WB_BUSY <= 1'b0;
      O_WB_BLOCK_DONE <= 1'b0;
    end else begin
      if_valid <= O_WB_OMEM_READ;
      if_last <= rd_last;
      if (push) begin
        f_data[wptr] <= push_data;
        f_be[wptr] <= push_be;
        f_last[wptr] <= if_last;
        wptr <= wptr + AW'(1);
      end
      if (pop)
        rptr <= rptr + AW'(1);
      cnt <= cnt_nxt[AW:0];
      O_WB_OMEM_READ <= issue;
      O_WB_BLOCK_DONE <= 1'b0;
      if (issue) begin
        O_WB_OMEM_ADDR0 <= {rd_cnt[5:0], 2'd0};
        O_WB_OMEM_ADDR1 <= {rd_cnt[5:0], 2'd1};
        O_WB_OMEM_ADDR2 <= {rd_cnt[5:0], 2'd2};
        O_WB_OMEM_ADDR3 <= {rd_cnt[5:0], 2'd3};
        rd_cnt <= rd_cnt + 7'd1;
        rd_last <= rd_cnt + 7'd1 == words;
      end
      if (state == IDLE && I_WB_START_BLOCK) begin
        state <= FETCH;
        O_WB_BUSY <= 1'b1;
        words <= words_in;
        last_be <= be_in;
        O_WB_OMEM_READ <= 1'b1;
        O_WB_OMEM_ADDR0 <= 8'd0;
        O_WB_OMEM_ADDR1 <= 8'd1;
        O_WB_OMEM_ADDR2 <= 8'd2;
        O_WB_OMEM_ADDR3 <= 8'd3;
        rd_cnt <= 7'd1;
        rd_last <= words_in == 7'd1;
      end else if (state == FETCH || state == DRAIN) begin
        if (pop && f_last[rptr]) begin
          state <= DONE;
          O_WB_BUSY <= 1'b0;
          O_WB_BLOCK_DONE <= 1'b1;
        end else if (state == FETCH && rd_cnt == words)
          state <= DRAIN;
      end else if (state == DONE)
        state <= IDLE;
    end
  end
endmodule

// File: tb/tb_core_writeback.sv
// tb_core_writeback: randomized scoreboard bench for core_writeback against a byte-level reference model
module tb_core_writeback;
  localparam int D = 4;
  localparam int BLK = 192;
  typedef struct {logic [31:0] d; logic [3:0] be; logic l;} wd_t;
  logic clk = 1'b0, rst, start, stop, ready;
  logic [7:0] count;
  logic read;
  logic [7:0] a0, a1, a2, a3, d0, d1, d2, d3;
  logic [31:0] hwdata;
  logic [3:0] be;
  logic valid, last, busy, block_done;
  logic [7:0] mem [256];
  wd_t sb [$];
  int errors = 0, checks = 0, cyc = 0, t0 = 0, acc = 0, rd_issued = 0, max_out = 0;
  int done_cnt = 0, exp_blocks = 0, last_cyc = 0;
  logic rmode = 1'b0;
  core_writeback #(.P_FIFO_DEPTH(D), .P_BLOCK_BYTES(BLK)) dut (
    .I_WB_HCLK(clk), .I_WB_RESET(rst), .I_WB_START_BLOCK(start), .I_WB_BYTE_COUNT(count),
    .I_WB_STOP(stop), .O_WB_OMEM_READ(read), .O_WB_OMEM_ADDR0(a0), .O_WB_OMEM_ADDR1(a1),
    .O_WB_OMEM_ADDR2(a2), .O_WB_OMEM_ADDR3(a3), .I_WB_OMEM_DATA0(d0), .I_WB_OMEM_DATA1(d1),
    .I_WB_OMEM_DATA2(d2), .I_WB_OMEM_DATA3(d3), .O_WB_HWDATA(hwdata), .O_WB_BYTE_EN(be),
    .O_WB_VALID(valid), .I_WB_DMA_READY(ready), .O_WB_LAST(last), .O_WB_BUSY(busy),
    .O_WB_BLOCK_DONE(block_done));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  function automatic wd_t model(input int cnt, input int w);
    int bytes = (cnt == 0 || cnt > BLK) ? BLK : cnt;
    int nw = (bytes + 3) / 4;
    int lane;
    wd_t r;
    r.d = 0;
    r.be = 0;
    for (int k = 0; k < 4; k++) begin
`ifdef CORE_WB_BYTE_SWAP_EN
      lane = 3 - k;
`else
      lane = k;
`endif
      if (4 * w + k < bytes) begin
        r.d[8*lane +: 8] = mem[(4 * w + k) % 256];
        r.be[lane] = 1'b1;
      end
    end
    r.l = (w == nw - 1);
    return r;
  endfunction
  // Memory responder: data for a read shows up throughout the following cycle
  always begin
    logic r;
    logic [7:0] x0, x1, x2, x3;
    @(negedge clk);
    r = read; x0 = a0; x1 = a1; x2 = a2; x3 = a3;
    @(posedge clk);
    #1;
    if (r) begin d0 = mem[x0]; d1 = mem[x1]; d2 = mem[x2]; d3 = mem[x3]; end
  end
  always begin
    @(posedge clk);
    #1;
    ready = rmode ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  always @(negedge clk) begin
    static logic prev_stall = 1'b0, exp_done = 1'b0;
    static logic [31:0] pd = 0;
    static logic [3:0] pbe = 0;
    static logic pl = 0;
    wd_t e;
    if (rst || stop) begin
      prev_stall = 1'b0;
      exp_done = 1'b0;
    end else begin
      if (exp_done || block_done) chk("block_done/busy", {block_done, busy}, {exp_done, 1'b0});
      if (block_done) done_cnt++;
      exp_done = 1'b0;
      if (prev_stall) chk("stall_hold", {valid, be, last, hwdata}, {1'b1, pbe, pl, pd});
      if (read) rd_issued++;
      if (valid && ready) begin
        if (sb.size() == 0) chk("unexpected_word", {valid, hwdata}, 0);
        else begin
          e = sb.pop_front();
          chk("word", {be, last, hwdata}, {e.be, e.l, e.d});
        end
        acc++;
        if (last) begin exp_done = 1'b1; last_cyc = cyc; end
      end
      if (rd_issued - acc > max_out) max_out = rd_issued - acc;
      prev_stall = valid && !ready;
      pd = hwdata; pbe = be; pl = last;
    end
  end
  task automatic check_reset(input string tag);
    chk({tag, "_ctrl"}, {read, valid, last, busy, block_done}, 0);
    chk({tag, "_data"}, {be, hwdata}, 0);
    chk({tag, "_addr"}, {a0, a1, a2, a3}, 32'h00010203);
  endtask
  task automatic start_block(input int cnt);
    int bytes = (cnt == 0 || cnt > BLK) ? BLK : cnt;
    for (int w = 0; w < (bytes + 3) / 4; w++) sb.push_back(model(cnt, w));
    acc = 0;
    rd_issued = 0;
    @(posedge clk);
    #1;
    count = 8'(cnt);
    start = 1'b1;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    exp_blocks++;
    while (done_cnt < exp_blocks && n < 3000) begin @(posedge clk); n++; end
    chk("block_timeout", 64'(done_cnt), 64'(exp_blocks));
    repeat (2) @(posedge clk);
    chk("sb_empty", 64'(sb.size()), 0);
  endtask
  task automatic wait_acc(input int target);
    int n = 0;
    while (acc < target && n < 2000) begin @(posedge clk); #1; n++; end
    chk("acc_timeout", 64'(acc >= target), 1);
  endtask
  initial begin
    wd_t f;
    rst = 1'b1; start = 1'b0; stop = 1'b0; count = 8'd0;
    d0 = 0; d1 = 0; d2 = 0; d3 = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    start_block(0);
    chk("c1_busy_read", {busy, read, a0}, {1'b1, 1'b1, 8'd0});
    @(posedge clk); #1;
    chk("c2_valid", 64'(valid), 0);
    @(posedge clk); #1;
    f = model(0, 0);
    chk("c3_first", {valid, hwdata}, {1'b1, f.d});
    wait_done();
    chk("full_latency_ok", 64'(last_cyc - t0 <= 52), 1);
    start_block(10);
    wait_done();
    rmode = 1'b1;
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      start_block(b == 0 ? 255 : $urandom_range(0, 255));
      wait_done();
    end
    start_block(1);
    wait_done();
    start_block(0);
    wait_acc(5);
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    sb.delete();
    chk("abort_idle", {valid, busy, read}, 0);
    repeat (4) @(posedge clk);
    chk("abort_no_done", 64'(done_cnt), 64'(exp_blocks));
    start_block(8);
    wait_done();
    start_block(0);
    wait_acc(20);
    rst = 1'b1;
    @(posedge clk); #1;
    check_reset("midrst");
    rst = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    chk("max_outstanding_ok", 64'(max_out <= D), 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1);
  end
endmodule
